// File: rtl/surf_wb_pkg.sv
// Shared types and helpers for the SURF WISHBONE interconnect.
// Arbiter state and round-robin grant selection.
package surf_wb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  localparam int SLOT_ID     = 0;
  localparam int MAX_MASTERS = 8;

  function automatic logic [2:0] rr_next(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] g;
    logic       hit;
    int         idx;
    g   = ptr;
    hit = 1'b0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !hit && req[idx]) begin
        g   = 3'(idx);
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/surf_wb_intercon_if.sv
// Bus bundle for the SURF WISHBONE interconnect.
// Master side, shared slave side and per-slave responses.
interface surf_wb_intercon_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 32
);

  logic [NUM_MASTERS-1:0]          m_cyc_i;
  logic [NUM_MASTERS-1:0]          m_stb_i;
  logic [NUM_MASTERS-1:0]          m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i;
  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i;
  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0]          m_ack_o;
  logic [NUM_MASTERS-1:0]          m_err_o;
  logic [DATA_W-1:0]               m_dat_o;

  logic [NUM_SLAVES-1:0]           s_cyc_o;
  logic [NUM_SLAVES-1:0]           s_stb_o;
  logic                            s_we_o;
  logic [ADDR_W-1:0]               s_adr_o;
  logic [DATA_W-1:0]               s_dat_o;
  logic [DATA_W/8-1:0]             s_sel_o;
  logic [NUM_SLAVES-1:0]           s_ack_i;
  logic [NUM_SLAVES-1:0]           s_err_i;
  logic [NUM_SLAVES*DATA_W-1:0]    s_dat_i;

  modport intercon (
    input  m_cyc_i, m_stb_i, m_we_i,
    input  m_adr_i, m_dat_i, m_sel_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o,
    output s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_err_i, s_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i,
    output m_adr_i, m_dat_i, m_sel_i,
    input  m_ack_o, m_err_o, m_dat_o
  );

  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o,
    input  s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_err_i, s_dat_i
  );

endinterface

// File: rtl/surf_wb_rr_arb.sv
// Round-robin bus arbiter, no preemption.
// Grant is held until the owner drops its request.
module surf_wb_rr_arb
  import surf_wb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt_oh,
  output logic [IW-1:0]          gnt_idx,
  output logic                   busy
);

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] nxt;
  logic [7:0]    req8;

  always_comb begin
    req8 = '0;
    req8[NUM_MASTERS-1:0] = req;
    nxt = IW'(rr_next(req8, 3'(rr_ptr), NUM_MASTERS));
  end

  assign busy = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_idx <= '0;
      gnt_oh  <= '0;
      rr_ptr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state   <= BUSY;
            gnt_idx <= nxt;
            gnt_oh  <= NUM_MASTERS'(1) << nxt;
          end
        end
        BUSY: begin
          if (!req[gnt_idx]) begin
            state  <= IDLE;
            gnt_oh <= '0;
            rr_ptr <= (gnt_idx == IW'(NUM_MASTERS - 1))
                      ? '0 : gnt_idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/surf_wb_intercon.sv
// SURF register-space WISHBONE interconnect: N masters, decoded
// slaves, built-in ID slave and stuck-slave timeout.
module surf_wb_intercon
  import surf_wb_pkg::*;
#(
  parameter int          NUM_MASTERS = 2,
  parameter int          NUM_SLAVES  = 3,
  parameter int          ADDR_W      = 22,
  parameter int          DATA_W      = 32,
  parameter int          DECODE_BITS = 2,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] IDENT       = "SURF",
  parameter logic [31:0] DATEVERSION = 32'h0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  surf_wb_intercon_if.intercon bus
);

  localparam int IW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SELW = DATA_W / 8;

  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [IW-1:0]          gnt;
  logic                   busy;

  surf_wb_rr_arb #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_arb (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .req    (bus.m_cyc_i),
    .gnt_oh (gnt_oh),
    .gnt_idx(gnt),
    .busy   (busy)
  );

  logic                   g_cyc;
  logic                   g_stb;
  logic [ADDR_W-1:0]      g_adr;
  logic [DECODE_BITS-1:0] slot;
  logic [DECODE_BITS-1:0] word;
  logic                   is_id;
  logic                   is_ext;

  always_comb begin
    g_cyc  = busy & bus.m_cyc_i[gnt];
    g_stb  = g_cyc & bus.m_stb_i[gnt];
    g_adr  = bus.m_adr_i[int'(gnt)*ADDR_W +: ADDR_W];
    slot   = g_adr[ADDR_W-1 -: DECODE_BITS];
    word   = g_adr[DECODE_BITS+1:2];
    is_id  = (int'(slot) == SLOT_ID);
    is_ext = !is_id && (int'(slot) <= NUM_SLAVES);
  end

  assign bus.s_we_o  = bus.m_we_i[gnt];
  assign bus.s_adr_o = g_adr;
  assign bus.s_dat_o = bus.m_dat_i[int'(gnt)*DATA_W +: DATA_W];
  assign bus.s_sel_o = bus.m_sel_i[int'(gnt)*SELW +: SELW];

  logic              ext_ack;
  logic              ext_err;
  logic [DATA_W-1:0] ext_dat;

  always_comb begin
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    ext_ack     = 1'b0;
    ext_err     = 1'b0;
    ext_dat     = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (is_ext && int'(slot) == k + 1) begin
        bus.s_cyc_o[k] = g_cyc;
        bus.s_stb_o[k] = g_stb;
        ext_ack        = bus.s_ack_i[k];
        ext_err        = bus.s_err_i[k];
        ext_dat        = bus.s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  logic [DATA_W-1:0] id_dat;

  always_comb begin
    id_dat = '0;
    unique case (1'b1)
      (word == '0):               id_dat = DATA_W'(IDENT);
      (word == DECODE_BITS'(1)):  id_dat = DATA_W'(DATEVERSION);
      default:                    id_dat = '0;
    endcase
  end

  logic              loc_ack_q;
  logic              loc_err_q;
  logic              to_err_q;
  logic [DATA_W-1:0] id_dat_q;
  logic [15:0]       to_cnt;
  logic              loc_req;
  logic              resp;
  logic              ack;
  logic              err;

  // Local responses drop for a cycle after each beat even with stb held.
  assign loc_req = g_stb && !is_ext && !(loc_ack_q || loc_err_q);
  assign resp    = ext_ack | ext_err | loc_ack_q | loc_err_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      loc_ack_q <= 1'b0;
      loc_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      id_dat_q  <= '0;
      to_cnt    <= '0;
    end else begin
      loc_ack_q <= loc_req && is_id;
      loc_err_q <= loc_req && !is_id;
      id_dat_q  <= id_dat;
      if (!g_stb || resp) begin
        to_cnt   <= '0;
        to_err_q <= 1'b0;
      end else if (to_cnt == 16'(TIMEOUT - 1)) begin
        to_cnt   <= '0;
        to_err_q <= 1'b1;
      end else begin
        to_cnt   <= to_cnt + 16'd1;
        to_err_q <= 1'b0;
      end
    end
  end

  // A real ack beats a coincident timeout.
  assign ack = g_cyc & (is_ext ? ext_ack : loc_ack_q);
  assign err = g_cyc & ~ack & (ext_err | loc_err_q | to_err_q);

  assign bus.m_ack_o = ack ? gnt_oh : '0;
  assign bus.m_err_o = err ? gnt_oh : '0;
  assign bus.m_dat_o = !busy  ? '0       :
                       is_id  ? id_dat_q :
                       is_ext ? ext_dat  : '0;

endmodule

// File: tb/tb_surf_wb_intercon.sv
// Randomised bench for surf_wb_intercon against a
// transaction-level model of arbitration, decode and timeout.
module tb_surf_wb_intercon;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [31:0] ID_W = 32'h5355_5246;
  localparam logic [31:0] DV_W = 32'h2024_0517;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  surf_wb_intercon_if #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .ADDR_W(AW), .DATA_W(DW)
  ) bus ();

  surf_wb_intercon #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .ADDR_W(AW), .DATA_W(DW), .DECODE_BITS(2),
    .TIMEOUT(TO), .IDENT(ID_W), .DATEVERSION(DV_W)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int ptr = 0;
  int lats [9] = '{0, 1, 2, 3, 5, 15, 16, 17, 99};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drv(input int m, input bit on,
                     input logic [AW-1:0] a, input bit we,
                     input logic [31:0] d, input logic [3:0] sel);
    bus.m_cyc_i[m] = on;
    bus.m_stb_i[m] = on;
    bus.m_we_i[m]  = we;
    bus.m_adr_i[m*AW +: AW] = a;
    bus.m_dat_i[m*DW +: DW] = d;
    bus.m_sel_i[m*4 +: 4]   = sel;
  endtask

  function automatic logic [AW-1:0] mk_adr(input int slot,
                                           input int word);
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[AW-1 -: 2] = 2'(slot);
    a[3:2] = 2'(word);
    return a;
  endfunction

  task automatic xfer(input int m, input int slot, input int word,
                      input bit we, input int lat);
    logic [AW-1:0] a, got_adr;
    logic [31:0] wd, sd, exp_dat, got_dat, got_wd;
    logic [3:0] sel, got_sel;
    logic [NM-1:0] got_ack, got_err;
    logic [NS-1:0] exp_scyc, got_scyc;
    logic got_we;
    int n, rc, exp_c, k;
    bit ext, exp_err;
    a = mk_adr(slot, word);
    wd = $urandom;
    sd = $urandom;
    sel = 4'($urandom);
    ext = (slot >= 1 && slot <= NS);
    k = ext ? slot - 1 : 0;
    exp_scyc = '0;
    exp_dat = '0;
    exp_c = 2;
    exp_err = 1'b1;
    if (slot == 0) begin
      exp_err = 1'b0;
      exp_dat = (word == 0) ? ID_W : (word == 1) ? DV_W : 32'h0;
    end else if (ext) begin
      exp_scyc = NS'(1) << k;
      exp_dat = sd;
      exp_err = (lat > TO);
      exp_c = 1 + ((lat > TO) ? TO : lat);
    end
    @(posedge clk); #1;
    drv(m, 1'b1, a, we, wd, sel);
    bus.s_dat_i[k*DW +: DW] = sd;
    n = 0;
    rc = -1;
    got_ack = '0; got_err = '0; got_dat = '0; got_scyc = '0;
    got_adr = '0; got_wd = '0; got_sel = '0; got_we = 1'b0;
    for (int c = 0; c < 40 && rc < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      bus.s_ack_i = '0;
      if (ext && bus.s_stb_o[k] && n == lat) bus.s_ack_i[k] = 1'b1;
      @(negedge clk);
      if (ext && bus.s_stb_o[k]) n++;
      if ((bus.m_ack_o | bus.m_err_o) != '0) begin
        rc = c;
        got_ack = bus.m_ack_o;
        got_err = bus.m_err_o;
        got_dat = bus.m_dat_o;
        got_scyc = bus.s_cyc_o;
        got_adr = bus.s_adr_o;
        got_wd = bus.s_dat_o;
        got_sel = bus.s_sel_o;
        got_we = bus.s_we_o;
      end
    end
    check("latency", 64'(rc), 64'(exp_c));
    check("ack", got_ack, exp_err ? '0 : NM'(1) << m);
    check("err", got_err, exp_err ? NM'(1) << m : '0);
    check("s_cyc", got_scyc, exp_scyc);
    if (!we && !exp_err) check("rdata", got_dat, exp_dat);
    if (ext) begin
      check("s_adr", got_adr, a);
      check("s_wr", {got_we, got_sel, got_wd}, {we, sel, wd});
    end
    @(posedge clk); #1;
    drv(m, 1'b0, a, we, wd, sel);
    bus.s_ack_i = '0;
    @(negedge clk);
    check("after", {bus.m_ack_o, bus.m_err_o}, '0);
    ptr = (m + 1) % NM;
  endtask

  task automatic contend();
    int w, l;
    logic [AW-1:0] a0, a1;
    w = ptr;
    l = (ptr + 1) % NM;
    a0 = mk_adr(1, int'($urandom % 4));
    a1 = mk_adr(1, int'($urandom % 4));
    @(posedge clk); #1;
    drv(0, 1'b1, a0, 1'b0, '0, '0);
    drv(1, 1'b1, a1, 1'b0, '0, '0);
    bus.s_ack_i = 2'b01;
    bus.s_dat_i[0 +: DW] = $urandom;
    @(negedge clk);
    check("arb_c0", bus.m_ack_o, '0);
    @(negedge clk);
    check("arb_win", bus.m_ack_o, NM'(1) << w);
    check("arb_adr", bus.s_adr_o, (w == 0) ? a0 : a1);
    @(posedge clk); #1;
    drv(w, 1'b0, (w == 0) ? a0 : a1, 1'b0, '0, '0);
    @(negedge clk);
    check("arb_gap1", bus.m_ack_o, '0);
    @(negedge clk);
    check("arb_gap2", bus.m_ack_o, '0);
    @(negedge clk);
    check("arb_next", bus.m_ack_o, NM'(1) << l);
    check("arb_nadr", bus.s_adr_o, (l == 0) ? a0 : a1);
    @(posedge clk); #1;
    drv(l, 1'b0, (l == 0) ? a0 : a1, 1'b0, '0, '0);
    bus.s_ack_i = '0;
    @(negedge clk);
    check("arb_end", bus.m_ack_o, '0);
    ptr = (l + 1) % NM;
  endtask

  task automatic hold_test();
    logic [4:0] pat;
    logic [AW-1:0] a;
    a = mk_adr(0, 1);
    pat = '0;
    @(posedge clk); #1;
    drv(0, 1'b1, a, 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      pat[c] = bus.m_ack_o[0];
    end
    check("hold_pat", pat, 5'b10100);
    @(posedge clk); #1;
    drv(0, 1'b0, a, 1'b0, '0, '0);
    @(negedge clk);
    ptr = 1;
  endtask

  task automatic rst_test();
    logic [AW-1:0] a;
    a = mk_adr(1, 0);
    @(posedge clk); #1;
    drv(1, 1'b1, a, 1'b0, '0, '0);
    bus.s_ack_i = 2'b01;
    bus.s_dat_i[0 +: DW] = 32'h8000_0001 | $urandom;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre", bus.m_ack_o, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_now", {bus.m_ack_o, bus.m_err_o, bus.s_cyc_o,
                      bus.s_stb_o, bus.m_dat_o}, '0);
    drv(1, 1'b0, a, 1'b0, '0, '0);
    bus.s_ack_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr = 0;
    @(negedge clk);
    check("rst_stale", {bus.m_ack_o, bus.m_err_o}, '0);
  endtask

  initial begin
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_ack_i = '0;
    bus.s_err_i = '0;
    bus.s_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp", {bus.m_ack_o, bus.m_err_o}, '0);
    check("rst_scyc", {bus.s_cyc_o, bus.s_stb_o}, '0);
    check("rst_dat", bus.m_dat_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    contend();
    xfer(0, 0, 0, 1'b0, 0);
    xfer(0, 0, 1, 1'b0, 0);
    contend();
    xfer(0, 2, 0, 1'b1, 3);
    xfer(1, 2, 0, 1'b0, 99);
    xfer(0, 3, 0, 1'b0, 0);
    xfer(1, 1, 2, 1'b0, 16);
    xfer(1, 0, 3, 1'b1, 0);
    hold_test();
    for (int i = 0; i < 30; i++) begin
      if ($urandom % 5 == 0) contend();
      else xfer(int'($urandom % NM), int'($urandom % 4),
                int'($urandom % 4), 1'($urandom),
                lats[$urandom % 9]);
    end
    rst_test();
    contend();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
